serial_subtractor: RTL and testbench

//  Multi-cycle two's-complement subtractor: diff = a - b - borrow_in.

---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings
// and a constant-foldable ceil(log2) helper for sizing counters.
package serial_arith_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor gate cell: d = x - y - bi with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, DIGIT bits per clock,
// LSB first, with valid/ready handshakes on both operand and result sides.
module serial_subtractor
    import serial_arith_defs::*;
#(
    parameter int N     = 16,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int STEPS = N / DIGIT;
    localparam int CNT_W = clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    generate
        if ((N % DIGIT) != 0) begin : g_bad_digit
            $error("serial_subtractor: N must be a multiple of DIGIT");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_acc;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic [DIGIT:0]     w_bchain;
    logic [DIGIT-1:0]   w_d;
    logic [N-1:0]       w_acc_next;
    logic               w_last;
    logic               w_accept;
    logic               w_in_ready;
    logic               w_out_valid;

    assign w_bchain[0] = r_borrow;

    generate
        for (genvar g = 0; g < DIGIT; g++) begin : g_cell
            full_subtractor u_fs (
                .x  (r_a[g]),
                .y  (r_b[g]),
                .bi (w_bchain[g]),
                .d  (w_d[g]),
                .bo (w_bchain[g+1])
            );
        end
    endgenerate

    // New slice enters at the top; after STEPS shifts slice 0 sits at bit 0.
    assign w_acc_next = (N'(w_d) << (N - DIGIT)) | (r_acc >> DIGIT);
    assign w_last     = (r_cnt == LAST);
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_borrow <= borrow_in;
        end else if (r_state == ST_RUN) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_borrow <= w_bchain[DIGIT];
            if (w_last) begin
                r_diff <= w_acc_next;
                r_bout <= w_bchain[DIGIT];
                r_ovf  <= (r_a_msb != r_b_msb) && (w_acc_next[N-1] != r_a_msb);
            end
        end
    end

    // Operand and accumulator datapath; contents are meaningless outside RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
            r_acc   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_acc <= w_acc_next;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_bout;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: DIGIT=1 and DIGIT=4 instances,
// directed vectors, backpressure and mid-operation reset.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;

    logic        in_valid1, in_ready1, bi1, out_valid1, out_ready1, bo1, ov1;
    logic [15:0] a1, b1, diff1;
    logic        in_valid4, in_ready4, bi4, out_valid4, out_ready4, bo4, ov4;
    logic [15:0] a4, b4, diff4;

    serial_subtractor #(.N(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .borrow_in(bi1), .out_valid(out_valid1),
        .out_ready(out_ready1), .diff(diff1), .borrow_out(bo1), .overflow(ov1)
    );

    serial_subtractor #(.N(16), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .borrow_in(bi4), .out_valid(out_valid4),
        .out_ready(out_ready4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
    );

    typedef struct {
        logic [15:0] diff;
        logic        bo;
        logic        ov;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   rise1 = 0;
    int   rise4 = 0;
    logic pv1 = 1'b0;
    logic pv4 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic mon_step();
        exp_t e;
        if (out_valid1 && !pv1) rise1 = cyc;
        pv1 = out_valid1;
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_unexpected_result: got diff %h with no pending operation", diff1);
            end else begin
                e = q1.pop_front();
                chk("d1_diff", 32'(diff1), 32'(e.diff));
                chk("d1_borrow_out", 32'(bo1), 32'(e.bo));
                chk("d1_overflow", 32'(ov1), 32'(e.ov));
                chk("d1_latency", 32'(rise1 - e.acc), 32'(e.lat));
            end
        end
        if (out_valid4 && !pv4) rise4 = cyc;
        pv4 = out_valid4;
        if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d4_unexpected_result: got diff %h with no pending operation", diff4);
            end else begin
                e = q4.pop_front();
                chk("d4_diff", 32'(diff4), 32'(e.diff));
                chk("d4_borrow_out", 32'(bo4), 32'(e.bo));
                chk("d4_overflow", 32'(ov4), 32'(e.ov));
                chk("d4_latency", 32'(rise4 - e.acc), 32'(e.lat));
            end
        end
    endtask

    // Called and returns at posedge+1: offers one operation and logs its expectation.
    task automatic issue(input int sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic biv, input logic [15:0] ed, input logic ebo, input logic eov);
        exp_t e;
        int   n;
        n = 0;
        while (((sel == 1) ? in_ready1 : in_ready4) !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready never rose on DIGIT=%0d instance", (sel == 1) ? 1 : 4);
        end else begin
            e.diff = ed;
            e.bo   = ebo;
            e.ov   = eov;
            e.acc  = cyc + 1;
            e.lat  = (sel == 1) ? 16 : 4;
            if (sel == 1) begin
                a1 = av; b1 = bv; bi1 = biv; in_valid1 = 1'b1;
                q1.push_back(e);
            end else begin
                a4 = av; b4 = bv; bi4 = biv; in_valid4 = 1'b1;
                q4.push_back(e);
            end
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            in_valid4 = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d and %0d results never delivered", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0; out_ready1 = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0; out_ready4 = 1'b1;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        chk("rst_diff1", 32'(diff1), 32'd0);
        chk("rst_borrow1", 32'(bo1), 32'd0);
        chk("rst_overflow1", 32'(ov1), 32'd0);
        chk("rst_in_ready4", 32'(in_ready4), 32'd1);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk("rst_diff4", 32'(diff4), 32'd0);
        rst_n = 1'b1;

        // Basic vectors, issued back to back (each waits for the IDLE slot).
        issue(1, 16'h1111, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        issue(1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        issue(1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        issue(1, 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0);
        drain();

        // Backpressure: result must hold and extra in_valid pulses be ignored.
        out_ready1 = 1'b0;
        issue(1, 16'h1234, 16'h0235, 1'b1, 16'h0FFE, 1'b0, 1'b0);
        n = 0;
        while (out_valid1 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL bp_wait: out_valid never rose, got %b required 1", out_valid1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid1), 32'd1);
            chk("bp_diff", 32'(diff1), 32'h0FFE);
            chk("bp_borrow", 32'(bo1), 32'd0);
            chk("bp_in_ready", 32'(in_ready1), 32'd0);
            in_valid1 = i[0];
            a1 = 16'hFFFF;
            b1 = 16'h0000;
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_in_ready", 32'(in_ready1), 32'd1);
        chk("pop_out_valid", 32'(out_valid1), 32'd0);
        chk("pop_diff_hold", 32'(diff1), 32'h0FFE);

        // Leaves nonzero diff/borrow/overflow in place before the reset test.
        issue(1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        drain();
        chk("held_overflow", 32'(ov1), 32'd1);

        // Reset during RUN abandons the operation.
        issue(1, 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q1.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid1), 32'd0);
        chk("midrst_in_ready", 32'(in_ready1), 32'd1);
        chk("midrst_diff", 32'(diff1), 32'd0);
        chk("midrst_borrow", 32'(bo1), 32'd0);
        chk("midrst_overflow", 32'(ov1), 32'd0);
        rst_n = 1'b1;
        issue(1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();

        // Four bits per cycle.
        issue(4, 16'h1234, 16'h0235, 1'b1, 16'h0FFE, 1'b0, 1'b0);
        issue(4, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        issue(4, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        issue(4, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        issue(4, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
